// File: rtl/audio_out_sched.sv
// Audio-out sample-rate scheduler: FIFO-buffered PCM samples, one issued per programmed period
// on a valid/ready stream, with zero/repeat underrun policy and saturating status counters.
module audio_out_sched #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int DIV_W  = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       cfg_enable,
   input  logic [DIV_W-1:0]           cfg_clkdiv,
   input  logic                       cfg_hold_last,
   input  logic                       clr_status,
   input  logic                       wr_valid,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   output logic                       smp_valid,
   output logic [DATA_W-1:0]          smp_data,
   input  logic                       smp_ready,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                underrun_cnt,
   output logic                       late_sticky,
   output logic                       busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              r_state, w_state_nxt;
   logic [DIV_W-1:0]    r_div, r_div_reload;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [LW-1:0]       r_level;
   logic [DATA_W-1:0]   r_last, r_smp_data;
   logic                r_smp_valid, r_late;
   logic [15:0]         r_underrun;

   logic w_push, w_hs, w_tick, w_slot_free, w_issue, w_empty, w_pop, w_underrun, w_late;

   assign w_push      = wr_valid && wr_ready;
   assign w_hs        = r_smp_valid && smp_ready;
   assign w_tick      = (r_state == S_RUN) && cfg_enable && (r_div == '0);
   // A handshake in the tick cycle frees the output slot before the tick looks at it.
   assign w_slot_free = !r_smp_valid || smp_ready;
   assign w_issue     = w_tick && w_slot_free;
   // Emptiness uses the registered level, so a same-cycle push cannot satisfy this tick.
   assign w_empty     = (r_level == '0);
   assign w_pop       = w_issue && !w_empty;
   assign w_underrun  = w_issue && w_empty;
   assign w_late      = w_tick && !w_slot_free;

   assign wr_ready     = (r_level != LW'(DEPTH));
   assign smp_valid    = r_smp_valid;
   assign smp_data     = r_smp_data;
   assign fifo_level   = r_level;
   assign underrun_cnt = r_underrun;
   assign late_sticky  = r_late;
   assign busy         = (r_state != S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (cfg_enable) w_state_nxt = S_RUN;
         S_RUN:   if (!cfg_enable) w_state_nxt = (r_smp_valid && !smp_ready) ? S_DRAIN : S_IDLE;
         S_DRAIN: if (w_hs) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_div_reload <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && cfg_enable) begin
            r_div_reload <= cfg_clkdiv;
            r_div        <= cfg_clkdiv;
         end else if (r_state == S_RUN) begin
            r_div <= (r_div == '0) ? r_div_reload : r_div - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_push) r_mem[r_wptr] <= wr_data;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_smp_valid <= 1'b0;
         r_smp_data  <= '0;
         r_last      <= '0;
      end else begin
         if (w_issue) begin
            r_smp_valid <= 1'b1;
            r_smp_data  <= w_pop ? r_mem[r_rptr] : (cfg_hold_last ? r_last : '0);
         end else if (w_hs) begin
            r_smp_valid <= 1'b0;
         end
         if (w_pop) r_last <= r_mem[r_rptr];
      end
   end

   // Clear takes priority over a coincident underrun or late event.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_underrun <= '0;
         r_late     <= 1'b0;
      end else if (clr_status) begin
         r_underrun <= '0;
         r_late     <= 1'b0;
      end else begin
         if (w_underrun && r_underrun != 16'hFFFF) r_underrun <= r_underrun + 16'd1;
         if (w_late) r_late <= 1'b1;
      end
   end
endmodule

// File: tb/tb_audio_out_sched.sv
// Directed bench for audio_out_sched: prefill, playback cadence, underrun policy and saturation,
// backpressure, full FIFO, drain on disable, asynchronous reset.
module tb_audio_out_sched;
   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cfg_enable, cfg_hold_last, clr_status;
   logic [15:0] cfg_clkdiv;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        smp_valid, smp_ready;
   logic [31:0] smp_data;
   logic [4:0]  fifo_level;
   logic [15:0] underrun_cnt;
   logic        late_sticky, busy;

   int errors = 0;
   int checks = 0;

   audio_out_sched #(.DATA_W(32), .DEPTH(16), .DIV_W(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cfg_enable(cfg_enable), .cfg_clkdiv(cfg_clkdiv), .cfg_hold_last(cfg_hold_last),
      .clr_status(clr_status),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
      .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
      .late_sticky(late_sticky), .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   task automatic cyc(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   initial begin
      ARESET = 1'b1; cfg_enable = 1'b0; cfg_clkdiv = 16'd0; cfg_hold_last = 1'b1;
      clr_status = 1'b0; wr_valid = 1'b0; wr_data = 32'd0; smp_ready = 1'b1;
      cyc(3);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_valid", 32'(smp_valid), 32'd0);
      chk("rst_data", smp_data, 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_underrun", 32'(underrun_cnt), 32'd0);
      chk("rst_late", 32'(late_sticky), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      ARESET = 1'b0;
      cyc(1);

      // Prefill while idle
      for (int i = 1; i <= 4; i++) begin
         wr_valid = 1'b1; wr_data = {16'(i), 16'(i)};
         cyc(1);
      end
      wr_valid = 1'b0;
      cyc(3);
      chk("prefill_level", 32'(fifo_level), 32'd4);
      chk("prefill_valid", 32'(smp_valid), 32'd0);
      chk("prefill_busy", 32'(busy), 32'd0);

      // Playback, period 10, first sample 11 cycles after enable
      cfg_clkdiv = 16'd9; cfg_enable = 1'b1;
      cyc(10);
      chk("play_pre_first", 32'(smp_valid), 32'd0);
      chk("play_busy", 32'(busy), 32'd1);
      cyc(1);
      chk("play1_valid", 32'(smp_valid), 32'd1);
      chk("play1_data", smp_data, 32'h00010001);
      chk("play1_level", 32'(fifo_level), 32'd3);
      for (int k = 2; k <= 4; k++) begin
         cyc(9);
         chk("play_gap", 32'(smp_valid), 32'd0);
         cyc(1);
         chk("play_valid", 32'(smp_valid), 32'd1);
         chk("play_data", smp_data, {16'(k), 16'(k)});
      end
      chk("play_level_empty", 32'(fifo_level), 32'd0);

      // Underrun: repeat last, then zero
      cyc(10);
      chk("ur_hold_data", smp_data, 32'h00040004);
      chk("ur_hold_cnt1", 32'(underrun_cnt), 32'd1);
      cyc(10);
      chk("ur_hold_data2", smp_data, 32'h00040004);
      chk("ur_hold_cnt2", 32'(underrun_cnt), 32'd2);
      cfg_hold_last = 1'b0;
      cyc(10);
      chk("ur_zero_valid", 32'(smp_valid), 32'd1);
      chk("ur_zero_data", smp_data, 32'd0);
      chk("ur_zero_cnt", 32'(underrun_cnt), 32'd3);

      cfg_enable = 1'b0;
      cyc(1);
      chk("dis_idle_busy", 32'(busy), 32'd0);
      chk("dis_idle_valid", 32'(smp_valid), 32'd0);
      clr_status = 1'b1;
      cyc(1);
      clr_status = 1'b0;
      chk("clr_underrun", 32'(underrun_cnt), 32'd0);

      // Saturation with a tick every cycle, handshake coinciding with every tick
      cfg_clkdiv = 16'd0; cfg_enable = 1'b1;
      cyc(100);
      chk("sat_cnt99", 32'(underrun_cnt), 32'd99);
      chk("sat_valid_held", 32'(smp_valid), 32'd1);
      chk("sat_no_late", 32'(late_sticky), 32'd0);
      cyc(65500);
      chk("sat_cnt", 32'(underrun_cnt), 32'h0000FFFF);
      cfg_enable = 1'b0;
      cyc(1);
      chk("sat_dis_busy", 32'(busy), 32'd0);
      clr_status = 1'b1;
      cyc(1);
      clr_status = 1'b0;

      // Backpressure
      for (int i = 1; i <= 4; i++) begin
         wr_valid = 1'b1; wr_data = {8{4'(i)}};
         cyc(1);
      end
      wr_valid = 1'b0;
      smp_ready = 1'b0; cfg_clkdiv = 16'd3; cfg_enable = 1'b1;
      cyc(5);
      chk("bp_valid", 32'(smp_valid), 32'd1);
      chk("bp_data", smp_data, 32'h11111111);
      chk("bp_no_late_yet", 32'(late_sticky), 32'd0);
      cyc(8);
      chk("bp_data_stable", smp_data, 32'h11111111);
      chk("bp_late", 32'(late_sticky), 32'd1);
      chk("bp_level", 32'(fifo_level), 32'd3);
      chk("bp_no_underrun", 32'(underrun_cnt), 32'd0);
      clr_status = 1'b1;
      cyc(1);
      clr_status = 1'b0;
      chk("bp_clr_late", 32'(late_sticky), 32'd0);
      smp_ready = 1'b1;
      cyc(1);
      chk("bp_hs_clear", 32'(smp_valid), 32'd0);
      cyc(2);
      chk("bp_next_valid", 32'(smp_valid), 32'd1);
      chk("bp_next_data", smp_data, 32'h22222222);
      chk("bp_next_level", 32'(fifo_level), 32'd2);

      // Disable with a sample pending: drain
      cfg_enable = 1'b0; smp_ready = 1'b0;
      cyc(1);
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_valid", 32'(smp_valid), 32'd1);
      cyc(3);
      chk("drain_data", smp_data, 32'h22222222);
      chk("drain_no_tick", 32'(fifo_level), 32'd2);
      smp_ready = 1'b1;
      cyc(1);
      chk("drain_done_valid", 32'(smp_valid), 32'd0);
      chk("drain_done_busy", 32'(busy), 32'd0);

      // Full FIFO: 18 pushes offered from level 2, 14 accepted
      for (int i = 0; i < 18; i++) begin
         wr_valid = 1'b1; wr_data = 32'hF0000000 + 32'(i);
         cyc(1);
      end
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      cfg_clkdiv = 16'd0; cfg_enable = 1'b1;
      cyc(1);
      chk("full_entry_level", 32'(fifo_level), 32'd16);
      cyc(1);
      chk("full_pop_level", 32'(fifo_level), 32'd15);
      chk("full_pop_data", smp_data, 32'h33333333);
      cyc(1);
      chk("pushpop_level", 32'(fifo_level), 32'd15);
      chk("pushpop_data", smp_data, 32'h44444444);
      cyc(1);
      chk("pushpop_level2", 32'(fifo_level), 32'd15);
      chk("wrap_data", smp_data, 32'hF0000000);
      cfg_enable = 1'b0;
      cyc(1);
      wr_valid = 1'b0;
      chk("refill_level", 32'(fifo_level), 32'd16);
      chk("refill_busy", 32'(busy), 32'd0);

      // Asynchronous reset mid-run
      cfg_enable = 1'b1;
      cyc(3);
      chk("arst_pre_busy", 32'(busy), 32'd1);
      chk("arst_pre_valid", 32'(smp_valid), 32'd1);
      #2;
      ARESET = 1'b1;
      #1;
      chk("arst_valid", 32'(smp_valid), 32'd0);
      chk("arst_data", smp_data, 32'd0);
      chk("arst_level", 32'(fifo_level), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_wr_ready", 32'(wr_ready), 32'd1);
      cfg_enable = 1'b0;
      cyc(2);
      ARESET = 1'b0;
      cyc(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
